// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: machine words, instruction words,
// the IF/ID pipeline record and the fetch FSM encoding.
package common;
    typedef logic [63:0] word_t;
    typedef logic [31:0] inst_t;

    localparam word_t DEFAULT_RESET_PC = 64'h8000_0000;
    localparam word_t ALIGN_MASK       = ~64'h3;
endpackage

package temp_storage;
    import common::*;

    typedef struct packed {
        inst_t inst;
        word_t inst_pc;
        logic  valid;
    } if_id;

    typedef enum logic [1:0] {
        REQ,
        HOLD,
        DRAIN
    } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface fetch_unit_if;
    import common::*;

    logic  imem_req_valid;
    word_t imem_req_addr;
    logic  imem_resp_data_ok;
    inst_t imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_resp_data_ok,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_resp_data_ok,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_unit_skid_buffer.sv
// One-entry holder for an instruction fetched while decode was stalled.
module fetch_skid_buffer
    import common::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  load_i,
    input  logic  unload_i,
    input  logic  clear_i,
    input  inst_t inst_i,
    input  word_t pc_i,
    output inst_t inst_o,
    output word_t pc_o,
    output logic  full_o
);

    inst_t inst_q;
    word_t pc_q;
    logic  full_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst_q <= '0;
            pc_q   <= '0;
            full_q <= 1'b0;
        end else if (clear_i || unload_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            inst_q <= inst_i;
            pc_q   <= pc_i;
            full_q <= 1'b1;
        end
    end

    assign inst_o = inst_q;
    assign pc_o   = pc_q;
    assign full_o = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem requests, PC tracking,
// registered IF/ID record, stall skid and redirect flush with drain.
module fetch_unit
    import common::*;
    import temp_storage::*;
#(
    parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                reset_n,
    fetch_unit_if.master        imem,
    input  logic                stall,
    input  logic                redirect_valid,
    input  word_t               redirect_pc,
    output if_id                if_id_state
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        drain_addr_q, drain_addr_d;
    if_id         ifid_q, ifid_d;

    logic  skid_load, skid_unload, skid_clear, skid_full;
    inst_t skid_inst;
    word_t skid_pc;
    word_t pc_next;

    fetch_skid_buffer u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .inst_i   (imem.imem_resp_data),
        .pc_i     (pc_q),
        .inst_o   (skid_inst),
        .pc_o     (skid_pc),
        .full_o   (skid_full)
    );

    assign pc_next = (pc_q + 64'd4) & ALIGN_MASK;

    // pc takes a redirect target immediately, so the stale address of the
    // request being drained is kept separately to hold the bus stable.
    assign imem.imem_req_valid = reset_n && (state_q == REQ || state_q == DRAIN);
    assign imem.imem_req_addr  = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign if_id_state         = ifid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC & ALIGN_MASK;
            drain_addr_q <= RESET_PC & ALIGN_MASK;
            ifid_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            ifid_q       <= ifid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        ifid_d       = ifid_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;

        if (state_q == REQ) drain_addr_d = pc_q;

        if (redirect_valid) begin
            pc_d         = redirect_pc & ALIGN_MASK;
            ifid_d.valid = 1'b0;
            skid_clear   = 1'b1;
            case (state_q)
                REQ:     state_d = imem.imem_resp_data_ok ? REQ : DRAIN;
                HOLD:    state_d = REQ;
                DRAIN:   state_d = DRAIN;
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    if (imem.imem_resp_data_ok) begin
                        if (!stall) begin
                            ifid_d = '{inst: imem.imem_resp_data, inst_pc: pc_q, valid: 1'b1};
                        end else begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end
                        pc_d = pc_next;
                    end else if (!stall) begin
                        ifid_d.valid = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall && skid_full) begin
                        ifid_d      = '{inst: skid_inst, inst_pc: skid_pc, valid: 1'b1};
                        skid_unload = 1'b1;
                        state_d     = REQ;
                    end
                end
                DRAIN: begin
                    if (imem.imem_resp_data_ok) state_d = REQ;
                end
                default: state_d = REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run checked against a program-order delivery scoreboard.
module tb_fetch_unit;
    import common::*;
    import temp_storage::*;

    localparam word_t RPC = 64'h8000_0000;

    logic  clk = 1'b0;
    logic  reset_n = 1'b0;
    logic  stall = 1'b0;
    logic  redirect_valid = 1'b0;
    word_t redirect_pc = '0;
    if_id  if_id_state;

    int checks = 0;
    int errors = 0;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem           (imem.master),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_state    (if_id_state)
    );

    always #5 clk = ~clk;

    // Memory model: answers after lat_v idle cycles, content derived from address.
    int unsigned lat_fixed = 0;
    int unsigned lat_rand = 0;
    bit          rand_lat = 1'b0;
    int unsigned lat_v;
    int unsigned wait_q = 0;
    int unsigned addr_violations = 0;
    word_t       last_addr = '0;

    function automatic inst_t mem_word(input word_t a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    assign lat_v = rand_lat ? lat_rand : lat_fixed;
    assign imem.imem_resp_data_ok = imem.imem_req_valid && (wait_q >= lat_v);
    assign imem.imem_resp_data    = mem_word(imem.imem_req_addr);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= 0;
        end else if (imem.imem_req_valid) begin
            if (wait_q > 0 && imem.imem_req_addr != last_addr)
                addr_violations <= addr_violations + 1;
            if (imem.imem_resp_data_ok) begin
                wait_q   <= 0;
                lat_rand <= $urandom_range(0, 2);
            end else begin
                wait_q <= wait_q + 1;
            end
            last_addr <= imem.imem_req_addr;
        end else begin
            wait_q <= 0;
        end
    end

    // Puts the bench at cycle 0: just after reset release, no inputs active.
    task automatic start();
        reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        rand_lat = 1'b0; lat_fixed = 0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        @(negedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (imem.imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL reset_req_valid got %b want 0", imem.imem_req_valid);
            end
            checks++;
            if (if_id_state !== if_id'('0)) begin
                errors++; $display("FAIL reset_ifid got %h want 0", if_id_state);
            end
            @(negedge clk); #1;
        end
        reset_n = 1'b1; #1;
        checks++;
        if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, RPC}) begin
            errors++; $display("FAIL reset_first_req got %b/%h want 1/%h",
                               imem.imem_req_valid, imem.imem_req_addr, RPC);
        end
    endtask

    task automatic test_stream();
        word_t e;
        start();
        for (int i = 0; i < 5; i++) begin
            e = RPC + 64'(4 * i);
            checks++;
            if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, e}) begin
                errors++; $display("FAIL stream_addr%0d got %b/%h want 1/%h",
                                   i, imem.imem_req_valid, imem.imem_req_addr, e);
            end
            if (i > 0) begin
                e = RPC + 64'(4 * (i - 1));
                checks++;
                if ({if_id_state.valid, if_id_state.inst_pc, if_id_state.inst} !== {1'b1, e, mem_word(e)}) begin
                    errors++; $display("FAIL stream_ifid%0d got %b/%h/%h want 1/%h/%h", i,
                                       if_id_state.valid, if_id_state.inst_pc, if_id_state.inst, e, mem_word(e));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        start();
        next_cycle();
        stall = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            next_cycle();
            if (i == 4) stall = 1'b0;
            checks++;
            if (imem.imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL stall_req_c%0d got %b want 0", i, imem.imem_req_valid);
            end
            checks++;
            if ({if_id_state.valid, if_id_state.inst_pc} !== {1'b1, RPC}) begin
                errors++; $display("FAIL stall_hold_c%0d got %b/%h want 1/%h",
                                   i, if_id_state.valid, if_id_state.inst_pc, RPC);
            end
        end
        next_cycle();
        checks++;
        if ({if_id_state.valid, if_id_state.inst_pc, if_id_state.inst} !== {1'b1, RPC + 64'd4, mem_word(RPC + 64'd4)}) begin
            errors++; $display("FAIL stall_release got %b/%h want 1/%h",
                               if_id_state.valid, if_id_state.inst_pc, RPC + 64'd4);
        end
        checks++;
        if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, RPC + 64'd8}) begin
            errors++; $display("FAIL stall_next_req got %b/%h want 1/%h",
                               imem.imem_req_valid, imem.imem_req_addr, RPC + 64'd8);
        end
    endtask

    task automatic test_redirect_drain();
        start();
        next_cycle();
        next_cycle();
        lat_fixed = 3; redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        #1;
        checks++;
        if (imem.imem_resp_data_ok !== 1'b0) begin
            errors++; $display("FAIL drain_pending got %b want 0", imem.imem_resp_data_ok);
        end
        for (int i = 3; i <= 5; i++) begin
            next_cycle();
            redirect_valid = 1'b0;
            checks++;
            if ({imem.imem_req_valid, imem.imem_req_addr, if_id_state.valid} !== {1'b1, RPC + 64'd8, 1'b0}) begin
                errors++; $display("FAIL drain_c%0d got %b/%h/%b want 1/%h/0", i,
                                   imem.imem_req_valid, imem.imem_req_addr, if_id_state.valid, RPC + 64'd8);
            end
        end
        next_cycle();
        lat_fixed = 0;
        checks++;
        if ({imem.imem_req_valid, imem.imem_req_addr, if_id_state.valid} !== {1'b1, 64'h8000_0100, 1'b0}) begin
            errors++; $display("FAIL drain_done got %b/%h/%b want 1/80000100/0",
                               imem.imem_req_valid, imem.imem_req_addr, if_id_state.valid);
        end
        next_cycle();
        checks++;
        if ({if_id_state.valid, if_id_state.inst_pc} !== {1'b1, 64'h8000_0100}) begin
            errors++; $display("FAIL drain_first_valid got %b/%h want 1/80000100",
                               if_id_state.valid, if_id_state.inst_pc);
        end
    endtask

    task automatic test_redirect_ok_stall();
        start();
        next_cycle();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        next_cycle();
        stall = 1'b0; redirect_valid = 1'b0;
        checks++;
        if ({if_id_state.valid, imem.imem_req_valid, imem.imem_req_addr} !== {1'b0, 1'b1, 64'h8000_0200}) begin
            errors++; $display("FAIL redir_ok_stall got %b/%b/%h want 0/1/80000200",
                               if_id_state.valid, imem.imem_req_valid, imem.imem_req_addr);
        end
        next_cycle();
        checks++;
        if ({if_id_state.valid, if_id_state.inst_pc} !== {1'b1, 64'h8000_0200}) begin
            errors++; $display("FAIL redir_ok_stall_next got %b/%h want 1/80000200",
                               if_id_state.valid, if_id_state.inst_pc);
        end
    endtask

    task automatic test_misaligned_and_wrap();
        start();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0103;
        next_cycle();
        redirect_valid = 1'b0;
        checks++;
        if (imem.imem_req_addr !== 64'h8000_0100) begin
            errors++; $display("FAIL misaligned_addr got %h want 80000100", imem.imem_req_addr);
        end
        next_cycle();
        checks++;
        if ({if_id_state.valid, if_id_state.inst_pc} !== {1'b1, 64'h8000_0100}) begin
            errors++; $display("FAIL misaligned_ifid got %b/%h want 1/80000100",
                               if_id_state.valid, if_id_state.inst_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        next_cycle();
        redirect_valid = 1'b0;
        checks++;
        if (imem.imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++; $display("FAIL wrap_addr got %h want fffffffffffffffc", imem.imem_req_addr);
        end
        next_cycle();
        checks++;
        if (imem.imem_req_addr !== 64'h0) begin
            errors++; $display("FAIL wrap_next got %h want 0", imem.imem_req_addr);
        end
        next_cycle();
        checks++;
        if ({if_id_state.valid, if_id_state.inst_pc, if_id_state.inst} !== {1'b1, 64'h0, mem_word(64'h0)}) begin
            errors++; $display("FAIL wrap_ifid got %b/%h want 1/0", if_id_state.valid, if_id_state.inst_pc);
        end
    endtask

    task automatic test_reset_mid_drain();
        start();
        lat_fixed = 5; redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
        next_cycle();
        redirect_valid = 1'b0;
        checks++;
        if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, RPC}) begin
            errors++; $display("FAIL mid_drain_req got %b/%h want 1/%h",
                               imem.imem_req_valid, imem.imem_req_addr, RPC);
        end
        reset_n = 1'b0; #1;
        checks++;
        if ({imem.imem_req_valid, if_id_state} !== {1'b0, if_id'('0)}) begin
            errors++; $display("FAIL mid_drain_reset got %b/%h want 0/0", imem.imem_req_valid, if_id_state);
        end
        next_cycle();
        reset_n = 1'b1; lat_fixed = 0; #1;
        checks++;
        if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, RPC}) begin
            errors++; $display("FAIL after_reset_req got %b/%h want 1/%h",
                               imem.imem_req_valid, imem.imem_req_addr, RPC);
        end
        next_cycle();
        checks++;
        if ({if_id_state.valid, if_id_state.inst_pc} !== {1'b1, RPC}) begin
            errors++; $display("FAIL after_reset_ifid got %b/%h want 1/%h",
                               if_id_state.valid, if_id_state.inst_pc, RPC);
        end
    endtask

    // Scoreboard: deliveries must follow program order from the latest
    // redirect target; stall freezes the record; redirect yields a bubble.
    task automatic test_random();
        word_t exp_pc;
        word_t p_tgt;
        logic  p_stall, p_redir;
        if_id  p_ifid;
        int    deliveries;
        exp_pc = RPC;
        deliveries = 0;
        start();
        rand_lat = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            stall = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = RPC + 64'($urandom_range(0, 4095));
            p_stall = stall; p_redir = redirect_valid;
            p_tgt = redirect_pc & ~64'h3;
            p_ifid = if_id_state;
            next_cycle();
            if (p_redir) begin
                checks++;
                if (if_id_state.valid !== 1'b0) begin
                    errors++; $display("FAIL rand_redir_bubble n=%0d got %b want 0", n, if_id_state.valid);
                end
                exp_pc = p_tgt;
            end else if (p_stall) begin
                checks++;
                if (if_id_state !== p_ifid) begin
                    errors++; $display("FAIL rand_stall_hold n=%0d got %h want %h", n, if_id_state, p_ifid);
                end
            end else if (if_id_state.valid) begin
                checks++;
                if ({if_id_state.inst_pc, if_id_state.inst} !== {exp_pc, mem_word(exp_pc)}) begin
                    errors++; $display("FAIL rand_delivery n=%0d got %h/%h want %h/%h", n,
                                       if_id_state.inst_pc, if_id_state.inst, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 64'd4;
                deliveries++;
            end
        end
        stall = 1'b0; redirect_valid = 1'b0;
        checks++;
        if (deliveries < 200) begin
            errors++; $display("FAIL rand_progress got %0d want >=200", deliveries);
        end
        checks++;
        if (addr_violations != 0) begin
            errors++; $display("FAIL rand_addr_stable got %0d want 0", addr_violations);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drain();
        test_redirect_ok_stall();
        test_misaligned_and_wrap();
        test_reset_mid_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
